// File: rtl/encoder_pkg.sv
// Shared definitions for the debounced 8-to-3 priority encoder:
// FSM state encoding, the default debounce length and the priority encoder.
package encoder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Index of the highest set bit; bit 7 wins. Returns 0 for an all-zero
    // vector, which callers must never rely on.
    function automatic logic [2:0] prio_enc8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = i[2:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
// Each bit is synchronized on its own; no cross-bit coherence is implied.
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/encoder_8to3_debounced.sv
// Debounced 8-to-3 priority encoder with a valid/ack handshake.
// Raw request lines are synchronized, the highest active line must stay the
// winner for DEBOUNCE_CYCLES samples, then its index is presented until the
// consumer acknowledges. A line that stays held never produces a second event.
module encoder_8to3_debounced
    import encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       sreq;
    logic [2:0]       sreq_idx;
    logic             sreq_any;
    state_t           state;
    logic [2:0]       cand;
    logic [CNT_W-1:0] cnt;

    sync_2ff #(
        .WIDTH (8)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req),
        .q     (sreq)
    );

    assign sreq_idx = prio_enc8(sreq);
    assign sreq_any = |sreq;

    // Main FSM; busy is updated together with every state change so it
    // always mirrors whether the state just entered is non-IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= 3'd0;
            cnt   <= '0;
            code  <= 3'd0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= 3'd0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sreq_any) begin
                        cand  <= sreq_idx;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                DEBOUNCE: begin
                    if (!sreq_any || (sreq_idx != cand)) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        code  <= cand;
                        valid <= 1'b1;
                        state <= HOLD;
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!sreq_any) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8to3_debounced.sv
// Directed bench for the debounced 8-to-3 encoder. Expected codes are queued
// when a press is driven and popped when valid rises.
module tb_encoder_8to3_debounced;

    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    encoder_8to3_debounced #(
        .DEBOUNCE_CYCLES (N),
        .CNT_W           (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .ack   (ack),
        .code  (code),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference priority encoder: scan from the top bit down.
    function automatic logic [2:0] model_code(input logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            if (r[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive a new request pattern at a falling edge; queue the code it should yield.
    task automatic applyStimulus(input logic [7:0] r, input bit expect_event);
        @(negedge clk);
        req = r;
        if (expect_event) exp_q.push_back(model_code(r));
    endtask

    // Wait for valid, then check latency (edges after the first sampling edge) and code.
    task automatic waitEvent(input string tag, input int exp_lat);
        int  edges;
        bit  seen;
        logic [2:0] expc;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (valid === 1'b1) seen = 1'b1;
        end
        checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({tag, "_lat"}, 32'(edges - 1), 32'(exp_lat));
            checkOutput({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                expc = exp_q.pop_front();
                checkOutput({tag, "_code"}, 32'(code), 32'(expc));
            end
        end
    endtask

    task automatic ackPulse(input string tag);
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid_after_ack"}, 32'(valid), 32'd0);
        checkOutput({tag, "_busy_after_ack"}, 32'(busy), 32'd1);
        @(negedge clk);
        ack = 1'b0;
    endtask

    // Drop all requests and require busy to clear within three edges.
    task automatic releaseAll(input string tag);
        int edges;
        applyStimulus(8'h00, 1'b0);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (busy !== 1'b0 && edges < 10);
        checkOutput({tag, "_idle_in_time"}, 32'(edges <= 3), 32'd1);
    endtask

    initial begin
        int   hits;
        logic any;

        rst_n = 1'b0;
        en    = 1'b1;
        req   = 8'h00;
        ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_code", 32'(code), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single line press");
        applyStimulus(8'b0000_0100, 1'b1);
        waitEvent("t1", N + 2);
        ackPulse("t1");
        releaseAll("t1");

        $display("[TB] multi line priority");
        applyStimulus(8'b1001_0001, 1'b1);
        waitEvent("t2a", N + 2);
        ackPulse("t2a");
        releaseAll("t2a");
        applyStimulus(8'b0000_0001, 1'b1);
        waitEvent("t2b", N + 2);
        ackPulse("t2b");
        releaseAll("t2b");

        $display("[TB] glitch rejection");
        applyStimulus(8'h08, 1'b0);
        @(negedge clk);
        applyStimulus(8'h00, 1'b0);
        any = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            any = any | valid;
        end
        checkOutput("t3_glitch_valid", 32'(any), 32'd0);
        checkOutput("t3_glitch_busy", 32'(busy), 32'd0);

        // 01 is accepted into DEBOUNCE, then 03 changes the winner; the abort
        // costs one extra IDLE sample, so valid lands N+3 edges after the change.
        applyStimulus(8'h01, 1'b0);
        @(negedge clk);
        applyStimulus(8'h03, 1'b1);
        waitEvent("t3_change", N + 3);
        ackPulse("t3");
        releaseAll("t3");

        $display("[TB] enable gating");
        @(negedge clk);
        en  = 1'b0;
        req = 8'hFF;
        any = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            any = any | valid | busy | (|code);
        end
        checkOutput("t4_disabled_quiet", 32'(any), 32'd0);
        @(negedge clk);
        en = 1'b1;
        exp_q.push_back(model_code(8'hFF));
        waitEvent("t4_enable", N);
        ackPulse("t4");
        releaseAll("t4");

        $display("[TB] held line yields one event");
        applyStimulus(8'h20, 1'b1);
        waitEvent("t5a", N + 2);
        ackPulse("t5a");
        hits = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) hits++;
        end
        checkOutput("t5_no_repeat", 32'(hits), 32'd0);
        releaseAll("t5a");
        applyStimulus(8'h20, 1'b1);
        waitEvent("t5b", N + 2);
        ackPulse("t5b");
        releaseAll("t5b");

        $display("[TB] async reset during hold");
        applyStimulus(8'h08, 1'b1);
        waitEvent("t6a", N + 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(valid), 32'd0);
        checkOutput("t6_rst_code", 32'(code), 32'd0);
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model_code(8'h08));
        waitEvent("t6b", N + 2);
        ackPulse("t6b");
        releaseAll("t6b");

        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
